// File: rtl/gcm_sram_job_sequencer.sv
// Job sequencer between the DMA stream and the GCM/AES engine SRAMs.
// Fill side loads upstream beats into inbound SRAM and hands the buffer off;
// drain side streams outbound SRAM results downstream through a 2-entry skid.
module gcm_sram_job_sequencer #(
  parameter int DW = 128,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          ib_wr_en,
  output logic [AW-1:0] ib_wr_addr,
  output logic [DW-1:0] ib_wr_data,
  output logic          ibDataValid,
  input  logic          ibSRAMValid,
  output logic [AW-1:0] job_len,
  input  logic          obDataValid,
  output logic          obSRAMValid,
  output logic          ob_rd_en,
  output logic [AW-1:0] ob_rd_addr,
  input  logic [DW-1:0] ob_rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          err_trunc
);

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  typedef enum logic [1:0] {F_IDLE, F_LOAD, F_HANDOFF, F_WAIT_FREE} fill_t;
  typedef enum logic [1:0] {D_IDLE, D_DRAIN, D_RELEASE} drain_t;

  fill_t         fill_state, fill_next;
  drain_t        drain_state, drain_next;
  logic [AW-1:0] wr_addr;
  logic          beat, close, push, pop, start;

  // Length FIFO: carries job lengths from the fill side to the drain side.
  logic [AW-1:0] fifo_mem [2];
  logic          fifo_wp, fifo_rp;
  logic [1:0]    fifo_cnt;
  logic          fifo_full, fifo_empty;

  // Drain-side read tracking and skid buffer.
  logic [AW-1:0] rd_addr, drain_len;
  logic          rd_done, inflight, inflight_last;
  logic [DW-1:0] skid_data [2];
  logic          skid_last [2];
  logic          skid_wp, skid_rp;
  logic [1:0]    skid_cnt;
  logic          take;
  logic [2:0]    occ_after;

  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign ib_wr_en   = beat;
  assign ib_wr_addr = wr_addr;
  assign ib_wr_data = s_data;
  assign ob_rd_addr = rd_addr;
  assign m_valid    = (skid_cnt != 2'd0);
  assign m_data     = skid_data[skid_rp];
  assign m_last     = skid_last[skid_rp];
  assign take       = m_valid & m_ready;
  // Occupancy once this cycle's returning read lands and any accepted beat leaves.
  assign occ_after  = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, take};

  // Fill FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fill_state <= F_IDLE;
    else       fill_state <= fill_next;
  end

  // Fill FSM next state, upstream ready and job close detection.
  always_comb begin
    fill_next = fill_state;
    s_ready   = 1'b0;
    beat      = 1'b0;
    close     = 1'b0;
    case (fill_state)
      F_IDLE: begin
        if (ibSRAMValid && !fifo_full) fill_next = F_LOAD;
        else                           fill_next = F_IDLE;
      end
      F_LOAD: begin
        s_ready = 1'b1;
        beat    = s_valid;
        close   = s_valid & (s_last | (wr_addr == ADDR_MAX));
        if (close) fill_next = F_HANDOFF;
        else       fill_next = F_LOAD;
      end
      F_HANDOFF: begin
        if (!ibSRAMValid) fill_next = F_WAIT_FREE;
        else              fill_next = F_HANDOFF;
      end
      F_WAIT_FREE: begin
        if (ibSRAMValid) fill_next = F_IDLE;
        else             fill_next = F_WAIT_FREE;
      end
      default: fill_next = F_IDLE;
    endcase
    push = close;
  end

  // Fill datapath: write address, handoff length, handoff flag, truncation pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_addr     <= {AW{1'b0}};
      job_len     <= {AW{1'b0}};
      ibDataValid <= 1'b0;
      err_trunc   <= 1'b0;
    end else begin
      err_trunc <= close & ~s_last;
      if (fill_state == F_IDLE)   wr_addr <= {AW{1'b0}};
      else if (beat && !close)    wr_addr <= wr_addr + {{(AW-1){1'b0}}, 1'b1};
      if (close) begin
        job_len     <= wr_addr;
        ibDataValid <= 1'b1;
      end else if (fill_state == F_HANDOFF && !ibSRAMValid) begin
        ibDataValid <= 1'b0;
      end
    end
  end

  // Length FIFO storage and pointers; simultaneous push/pop keeps occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_mem[0] <= {AW{1'b0}};
      fifo_mem[1] <= {AW{1'b0}};
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push && (!fifo_full || pop)) begin
        fifo_mem[fifo_wp] <= wr_addr;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      case ({push && (!fifo_full || pop), pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drain_state <= D_IDLE;
    else       drain_state <= drain_next;
  end

  // Drain FSM next state, read issue and FIFO pop.
  always_comb begin
    drain_next = drain_state;
    ob_rd_en   = 1'b0;
    pop        = 1'b0;
    start      = 1'b0;
    case (drain_state)
      D_IDLE: begin
        start = obDataValid & ~fifo_empty;
        if (start) drain_next = D_DRAIN;
        else       drain_next = D_IDLE;
      end
      D_DRAIN: begin
        ob_rd_en = ~rd_done & (occ_after < 3'd2);
        if (take && m_last) begin
          pop        = 1'b1;
          drain_next = D_RELEASE;
        end else begin
          drain_next = D_DRAIN;
        end
      end
      D_RELEASE: begin
        if (!obDataValid) drain_next = D_IDLE;
        else              drain_next = D_RELEASE;
      end
      default: drain_next = D_IDLE;
    endcase
  end

  // Drain datapath: latched length, read address, outbound buffer ownership.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drain_len     <= {AW{1'b0}};
      rd_addr       <= {AW{1'b0}};
      rd_done       <= 1'b0;
      obSRAMValid   <= 1'b1;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= ob_rd_en;
      inflight_last <= ob_rd_en & (rd_addr == drain_len);
      if (start) begin
        drain_len   <= fifo_mem[fifo_rp];
        rd_addr     <= {AW{1'b0}};
        rd_done     <= 1'b0;
        obSRAMValid <= 1'b0;
      end else if (ob_rd_en) begin
        if (rd_addr == drain_len) rd_done <= 1'b1;
        else                      rd_addr <= rd_addr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) obSRAMValid <= 1'b1;
    end
  end

  // Skid buffer: captures returning read data, presents it on m_*.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        skid_data[i] <= {DW{1'b0}};
        skid_last[i] <= 1'b0;
      end
      skid_wp  <= 1'b0;
      skid_rp  <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (inflight) begin
        skid_data[skid_wp] <= ob_rd_data;
        skid_last[skid_wp] <= inflight_last;
        skid_wp            <= ~skid_wp;
      end
      if (take) skid_rp <= ~skid_rp;
      case ({inflight, take})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_sram_job_sequencer.sv
// Self-checking bench: scoreboards for inbound writes, handoff lengths and
// downstream beats, plus a small engine model for the SRAM handshakes.
module tb_gcm_sram_job_sequencer;
  localparam int DW = 128;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          ib_wr_en;
  logic [AW-1:0] ib_wr_addr;
  logic [DW-1:0] ib_wr_data;
  logic          ibDataValid, ibSRAMValid = 1'b1;
  logic [AW-1:0] job_len;
  logic          obDataValid = 1'b0, obSRAMValid, ob_rd_en;
  logic [AW-1:0] ob_rd_addr;
  logic [DW-1:0] ob_rd_data = '0;
  logic          m_valid, m_ready = 1'b1, m_last, err_trunc;
  logic [DW-1:0] m_data;

  int checks = 0, passes = 0;
  int model_addr = 0, trunc_seen = 0;
  bit eng_auto = 1'b0, m_toggle = 1'b0;

  logic [AW+DW-1:0] ib_q [$];
  logic [AW-1:0]    jl_q [$];
  logic [DW:0]      m_q  [$];
  logic [DW-1:0]    ob_mem [256];

  logic [AW+DW-1:0] ib_exp;
  logic [DW:0]      m_exp;
  logic [AW-1:0]    jl_exp;
  bit               stall_prev = 1'b0;
  logic [DW-1:0]    stall_data;
  logic             stall_last;

  always #5 clk = ~clk;

  gcm_sram_job_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .ib_wr_en(ib_wr_en), .ib_wr_addr(ib_wr_addr), .ib_wr_data(ib_wr_data),
    .ibDataValid(ibDataValid), .ibSRAMValid(ibSRAMValid), .job_len(job_len),
    .obDataValid(obDataValid), .obSRAMValid(obSRAMValid),
    .ob_rd_en(ob_rd_en), .ob_rd_addr(ob_rd_addr), .ob_rd_data(ob_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err_trunc(err_trunc)
  );

  // Outbound SRAM model: one-cycle read latency.
  always @(posedge clk) if (ob_rd_en) ob_rd_data <= ob_mem[ob_rd_addr];

  // Downstream ready: held high, or toggled every cycle.
  initial forever begin
    @(posedge clk); #1;
    m_ready = m_toggle ? ~m_ready : 1'b1;
  end

  // Monitors: inbound writes, truncation pulse, stall stability, downstream beats.
  always @(negedge clk) begin
    if (rstn) begin
      if (ib_wr_en) begin
        checks++;
        if (ib_q.size() == 0) $display("FAIL ib_write: unexpected write addr=%0h data=%h", ib_wr_addr, ib_wr_data);
        else begin
          ib_exp = ib_q.pop_front();
          if ({ib_wr_addr, ib_wr_data} !== ib_exp)
            $display("FAIL ib_write: got addr=%0h data=%h expected addr=%0h data=%h",
                     ib_wr_addr, ib_wr_data, ib_exp[AW+DW-1:DW], ib_exp[DW-1:0]);
          else passes++;
        end
      end
      if (err_trunc) begin
        trunc_seen++;
        checks++;
        if (ibDataValid !== 1'b1 || job_len !== 8'hFF)
          $display("FAIL trunc_pulse: ibDataValid=%b job_len=%0d expected 1 and 255", ibDataValid, job_len);
        else passes++;
      end
      if (stall_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== stall_data || m_last !== stall_last)
          $display("FAIL stall_hold: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                   m_valid, m_data, m_last, stall_data, stall_last);
        else passes++;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_q.size() == 0) $display("FAIL m_beat: unexpected beat data=%h last=%b", m_data, m_last);
        else begin
          m_exp = m_q.pop_front();
          if ({m_last, m_data} !== m_exp)
            $display("FAIL m_beat: got data=%h last=%b expected data=%h last=%b",
                     m_data, m_last, m_exp[DW-1:0], m_exp[DW]);
          else passes++;
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Engine model: checks handed-off length, consumes the inbound buffer, frees it.
  initial forever begin
    @(negedge clk);
    if (eng_auto && rstn && ibDataValid) begin
      checks++;
      if (jl_q.size() == 0) $display("FAIL job_len: unexpected handoff job_len=%0d", job_len);
      else begin
        jl_exp = jl_q.pop_front();
        if (job_len !== jl_exp) $display("FAIL job_len: got %0d expected %0d", job_len, jl_exp);
        else passes++;
      end
      @(posedge clk); #1 ibSRAMValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ibDataValid !== 1'b0) $display("FAIL handoff_clear: ibDataValid=%b expected 0", ibDataValid);
      else passes++;
      ibSRAMValid = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    eng_auto = 1'b0; m_toggle = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    ibSRAMValid = 1'b1; obDataValid = 1'b0;
    ib_q.delete(); jl_q.delete(); m_q.delete();
    model_addr = 0; trunc_seen = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    tick();
  endtask

  // Drive n beats; the model tracks the expected address and job closes.
  task automatic send_stream(input int n, input bit with_last, input logic [31:0] seed);
    logic [DW-1:0] d;
    bit last, cls;
    int cnt;
    for (int i = 0; i < n; i++) begin
      last = with_last && (i == n - 1);
      d = {seed, 32'h0000_00A5, 32'h0, 32'(i)};
      ib_q.push_back({model_addr[AW-1:0], d});
      s_valid = 1'b1; s_data = d; s_last = last;
      cnt = 0;
      @(negedge clk);
      while (!s_ready && cnt < 200) begin @(negedge clk); cnt++; end
      if (!s_ready) begin
        checks++;
        $display("FAIL s_ready_timeout: beat %0d s_ready=%b expected 1", i, s_ready);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      cls = last || (model_addr == 255);
      if (cls) begin
        jl_q.push_back(model_addr[AW-1:0]);
        model_addr = 0;
      end else begin
        model_addr++;
      end
      tick();
      if (cls) begin
        checks++;
        if (ibDataValid !== 1'b1) $display("FAIL last_to_ibdv: ibDataValid=%b expected 1", ibDataValid);
        else passes++;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Drain one job of n beats; checks start latency, ownership and completion.
  task automatic drain_job(input int n, input logic [31:0] seed);
    logic [DW-1:0] d;
    int cnt;
    for (int i = 0; i < n; i++) begin
      d = {seed, 32'h0000_00D0, 32'h0, 32'(i)};
      ob_mem[i] = d;
      m_q.push_back({(i == n - 1), d});
    end
    obDataValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || obSRAMValid !== 1'b0)
      $display("FAIL drain_start: m_valid=%b obSRAMValid=%b expected 0 and 0", m_valid, obSRAMValid);
    else passes++;
    tick();
    checks++;
    if (m_valid !== 1'b1) $display("FAIL drain_latency: m_valid=%b expected 1", m_valid);
    else passes++;
    cnt = 0;
    while (obSRAMValid !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    checks++;
    if (obSRAMValid !== 1'b1) $display("FAIL drain_release: obSRAMValid=%b expected 1", obSRAMValid);
    else passes++;
    checks++;
    if (m_q.size() != 0) $display("FAIL drain_count: %0d beats missing expected 0", m_q.size());
    else passes++;
    tick();
    obDataValid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, ib_wr_en, ib_wr_addr, ibDataValid, job_len, obSRAMValid, ob_rd_en,
         ob_rd_addr, m_valid, m_last, err_trunc} !== {2'b00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000})
      $display("FAIL reset_values: s_ready=%b ib_wr_en=%b ibDV=%b job_len=%0d obSV=%b rd_en=%b m_valid=%b",
               s_ready, ib_wr_en, ibDataValid, job_len, obSRAMValid, ob_rd_en, m_valid);
    else passes++;
    s_valid = 1'b0;
    apply_reset();
  endtask

  task automatic test_fill_basic();
    eng_auto = 1'b1;
    send_stream(4, 1'b1, 32'h1111_0001);
    repeat (6) tick();
    checks++;
    if (ib_q.size() != 0 || jl_q.size() != 0)
      $display("FAIL fill_basic: ib_q=%0d jl_q=%0d left expected 0", ib_q.size(), jl_q.size());
    else passes++;
  endtask

  task automatic test_drain_basic();
    drain_job(4, 32'h2222_0002);
  endtask

  task automatic test_truncation();
    apply_reset();
    eng_auto = 1'b1;
    send_stream(300, 1'b1, 32'h3333_0003);
    repeat (6) tick();
    checks++;
    if (trunc_seen != 1) $display("FAIL trunc_count: got %0d pulses expected 1", trunc_seen);
    else passes++;
    checks++;
    if (jl_q.size() != 0 || ib_q.size() != 0)
      $display("FAIL trunc_jobs: jl_q=%0d ib_q=%0d left expected 0", jl_q.size(), ib_q.size());
    else passes++;
  endtask

  task automatic test_stall_drain();
    apply_reset();
    eng_auto = 1'b1;
    send_stream(16, 1'b1, 32'h4444_0004);
    repeat (6) tick();
    m_toggle = 1'b1;
    drain_job(16, 32'h5555_0005);
    m_toggle = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] d;
    int cnt;
    bit leaked;
    apply_reset();
    eng_auto = 1'b1;
    send_stream(3, 1'b1, 32'h6666_0006);
    send_stream(2, 1'b1, 32'h6666_0007);
    repeat (8) tick();
    d = {32'h6666_0008, 32'h0000_00A5, 32'h0, 32'h0};
    ib_q.push_back({8'h00, d});
    jl_q.push_back(8'h00);
    s_valid = 1'b1; s_data = d; s_last = 1'b1;
    leaked = 1'b0;
    repeat (20) begin @(negedge clk); if (s_ready) leaked = 1'b1; end
    checks++;
    if (leaked) $display("FAIL fifo_full_block: s_ready=1 expected 0 while FIFO full");
    else passes++;
    for (int i = 0; i < 3; i++) begin
      ob_mem[i] = {32'h7777_0009, 32'h0000_00D0, 32'h0, 32'(i)};
      m_q.push_back({(i == 2), ob_mem[i]});
    end
    tick();
    obDataValid = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!s_ready && cnt < 100) begin @(negedge clk); cnt++; end
    checks++;
    if (!s_ready) $display("FAIL fifo_pop_unblock: s_ready=%b expected 1", s_ready);
    else passes++;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    obDataValid = 1'b0;
    repeat (8) tick();
    checks++;
    if (m_q.size() != 0 || ib_q.size() != 0 || jl_q.size() != 0)
      $display("FAIL fifo_full_jobs: m_q=%0d ib_q=%0d jl_q=%0d left expected 0", m_q.size(), ib_q.size(), jl_q.size());
    else passes++;
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    eng_auto = 1'b1;
    send_stream(5, 1'b0, 32'h8888_000A);
    s_valid = 1'b1; s_data = {4{32'hDEAD_BEEF}};
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, ib_wr_en, ib_wr_addr, ibDataValid, job_len, obSRAMValid, ob_rd_en,
         ob_rd_addr, m_valid, m_last, err_trunc} !== {2'b00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000})
      $display("FAIL midload_reset: s_ready=%b ib_wr_en=%b ib_wr_addr=%0d ibDV=%b job_len=%0d obSV=%b",
               s_ready, ib_wr_en, ib_wr_addr, ibDataValid, job_len, obSRAMValid);
    else passes++;
    s_valid = 1'b0;
    apply_reset();
    eng_auto = 1'b1;
    send_stream(2, 1'b1, 32'h9999_000B);
    repeat (6) tick();
    checks++;
    if (ib_q.size() != 0 || jl_q.size() != 0)
      $display("FAIL midload_refill: ib_q=%0d jl_q=%0d left expected 0", ib_q.size(), jl_q.size());
    else passes++;
    drain_job(2, 32'hAAAA_000C);
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_drain_basic();
    test_truncation();
    test_stall_drain();
    test_fifo_full();
    test_reset_mid_load();
    repeat (4) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
